// File: rtl/linear_fixed_to_log_unit.sv
// Converts a signed linear fixed-point accumulator word into a packed log-domain word {sign, exp, frac}.
// Latency 2 cycles (two register stages), one word per cycle.
// No backpressure: both stages advance every cycle and outValid follows inValid.
module linear_fixed_to_log_unit #(
  parameter int ACC_NON_FRAC       = 8,
  parameter int ACC_FRAC           = 8,
  parameter int M                  = 4,
  parameter int F                  = 3,
  parameter int LINEAR_TO_LOG_BITS = 8,
  parameter int USE_ADJUST         = 0,
  parameter int ADJUST_EXP_SIZE    = 1,
  parameter int SATURATE_MAX       = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             inValid,
  input  logic [ACC_NON_FRAC+ACC_FRAC-1:0] inAcc,
  input  logic                             inIsInf,
  input  logic [ADJUST_EXP_SIZE-1:0]       adjustExp,
  output logic                             outValid,
  output logic [M+F:0]                     outData,
  output logic                             outIsZero,
  output logic                             outIsInf
);

  localparam int W  = ACC_NON_FRAC + ACC_FRAC;
  localparam int L  = LINEAR_TO_LOG_BITS;
  localparam int TW = F + 2;
  localparam int PW = $clog2(W + 1);
  localparam int EW = ((PW > ADJUST_EXP_SIZE) ? PW : ADJUST_EXP_SIZE) + M + 2;

  localparam logic signed [EW-1:0] MAX_EXP = EW'((1 << (M - 1)) - 1);
  localparam logic signed [EW-1:0] MIN_EXP = EW'(-(1 << (M - 1)));

  // log2(1 + idx/2^L) truncated to TW fraction bits. Digits come from repeated
  // squaring of a 30-bit fixed-point value in [1,2): squaring doubles the log,
  // so each step that lands at >= 2 contributes a one bit.
  function automatic logic [TW-1:0] log_frac(input int idx);
    logic [63:0]   x;
    logic [TW-1:0] r;
    x = 64'((1 << L) + idx) << (30 - L);
    r = '0;
    for (int b = 0; b < TW; b++) begin
      x = (x * x) >> 30;
      if (x >= (64'd1 << 31)) begin
        r = {r[TW-2:0], 1'b1};
        x = x >> 1;
      end else begin
        r = {r[TW-2:0], 1'b0};
      end
    end
    return r;
  endfunction

  logic [TW-1:0] log_table [0:(1<<L)-1];
  for (genvar gi = 0; gi < (1 << L); gi++) begin : g_log_table
    assign log_table[gi] = log_frac(gi);
  end

  // ---------------- stage 1 combinational ----------------
  logic [W:0]             mag;
  logic [PW-1:0]          lead_pos;
  logic [PW-1:0]          shift_amt;
  logic [W-1:0]           below;
  logic [W+L-1:0]         frac_ext;
  logic [L-1:0]           tab_idx;
  logic                   rem_any;
  logic signed [EW-1:0]   exp_raw;

  // Magnitude (one extra bit so the most negative input stays exact), leading-one
  // position, and the left-aligned bits under the leading one.
  always_comb begin
    mag = inAcc[W-1] ? (~{inAcc[W-1], inAcc} + (W+1)'(1)) : {1'b0, inAcc};
    lead_pos = '0;
    for (int i = 0; i <= W; i++) begin
      if (mag[i]) lead_pos = PW'(i);
    end
    shift_amt = PW'(W) - lead_pos;
    below     = W'(mag << shift_amt);
    frac_ext  = {below, {L{1'b0}}};
    tab_idx   = frac_ext[W+L-1 -: L];
    rem_any   = |frac_ext[W-1:0];
    exp_raw   = $signed({{(EW-PW){1'b0}}, lead_pos}) - EW'(ACC_FRAC);
  end

  // ---------------- stage 1 registers ----------------
  logic                       s1_vld;
  logic                       s1_sign;
  logic signed [EW-1:0]       s1_exp;
  logic [TW-1:0]              s1_tab;
  logic                       s1_sticky;
  logic                       s1_zero;
  logic                       s1_inf;
  logic [ADJUST_EXP_SIZE-1:0] s1_adj;

  // Capture sign, exponent, table value and flags. log2(1+k/2^L) is irrational
  // for every k > 0, so the truncated table tail is nonzero exactly when k != 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_tab    <= '0;
      s1_sticky <= 1'b0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_adj    <= '0;
    end else begin
      s1_vld    <= inValid;
      s1_sign   <= inAcc[W-1];
      s1_exp    <= exp_raw;
      s1_tab    <= log_table[tab_idx];
      s1_sticky <= rem_any | (tab_idx != '0);
      s1_zero   <= (mag == '0);
      s1_inf    <= inIsInf;
      s1_adj    <= adjustExp;
    end
  end

  // ---------------- stage 2 combinational ----------------
  logic                 round_up;
  logic [F:0]           q_sum;
  logic [F-1:0]         frac_r;
  logic signed [EW-1:0] exp_rnd;
  logic signed [EW-1:0] adj_ext;
  logic signed [EW-1:0] exp_adj;
  logic [M+F:0]         n_data;
  logic                 n_zero;
  logic                 n_inf;

  // Round to nearest even, apply the exponent offset, then saturate or flush and pack.
  // Exponent MIN_EXP with a zero fraction is the Inf encoding, so that value flushes to zero.
  always_comb begin
    round_up = s1_tab[1] & (s1_tab[0] | s1_sticky | s1_tab[2]);
    q_sum    = {1'b0, s1_tab[TW-1:2]} + (F+1)'(round_up);
    frac_r   = q_sum[F-1:0];
    exp_rnd  = s1_exp + EW'(q_sum[F]);
    adj_ext  = EW'($signed(s1_adj));
    exp_adj  = exp_rnd;
    if (USE_ADJUST != 0) exp_adj = exp_rnd + adj_ext;

    n_data = '0;
    n_zero = 1'b0;
    n_inf  = 1'b0;
    if (s1_inf) begin
      n_inf  = 1'b1;
      n_data = {s1_sign, 1'b1, {(M+F-1){1'b0}}};
    end else if (s1_zero) begin
      n_zero = 1'b1;
    end else if (exp_adj > MAX_EXP) begin
      if (SATURATE_MAX != 0) begin
        n_data = {s1_sign, MAX_EXP[M-1:0], {F{1'b1}}};
      end else begin
        n_inf  = 1'b1;
        n_data = {s1_sign, 1'b1, {(M+F-1){1'b0}}};
      end
    end else if ((exp_adj < MIN_EXP) || ((exp_adj == MIN_EXP) && (frac_r == '0))) begin
      n_zero = 1'b1;
    end else begin
      n_data = {s1_sign, exp_adj[M-1:0], frac_r};
    end
  end

  // ---------------- stage 2 registers ----------------
  // Output register; valid tracks stage-1 valid one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      outValid  <= 1'b0;
      outData   <= '0;
      outIsZero <= 1'b0;
      outIsInf  <= 1'b0;
    end else begin
      outValid  <= s1_vld;
      outData   <= n_data;
      outIsZero <= n_zero;
      outIsInf  <= n_inf;
    end
  end

endmodule

// File: tb/tb_linear_fixed_to_log_unit.sv
// Self-checking bench for linear_fixed_to_log_unit: directed table, overflow/adjust
// instances, and a random stream with a mid-stream reset checked through a scoreboard.
module tb_linear_fixed_to_log_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_acc;
  logic        in_inf;
  logic [0:0]  adj1;
  logic [3:0]  adj4;

  logic        out_valid, out_zero, out_inf;
  logic [7:0]  out_data;
  logic        sat_valid, sat_zero, sat_inf;
  logic [7:0]  sat_data;
  logic        ovf_valid, ovf_zero, ovf_inf;
  logic [7:0]  ovf_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [9:0] res;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] acc;
    logic        inf;
    logic [7:0]  data;
    logic        zero;
    logic        is_inf;
  } vec_t;
  vec_t tab[13];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  linear_fixed_to_log_unit dut (
    .clock(clock), .reset(reset), .inValid(in_valid), .inAcc(in_acc), .inIsInf(in_inf),
    .adjustExp(adj1), .outValid(out_valid), .outData(out_data), .outIsZero(out_zero),
    .outIsInf(out_inf));

  linear_fixed_to_log_unit #(.USE_ADJUST(1), .ADJUST_EXP_SIZE(4), .SATURATE_MAX(1)) dut_sat (
    .clock(clock), .reset(reset), .inValid(in_valid), .inAcc(in_acc), .inIsInf(in_inf),
    .adjustExp(adj4), .outValid(sat_valid), .outData(sat_data), .outIsZero(sat_zero),
    .outIsInf(sat_inf));

  linear_fixed_to_log_unit #(.USE_ADJUST(1), .ADJUST_EXP_SIZE(4), .SATURATE_MAX(0)) dut_ovf (
    .clock(clock), .reset(reset), .inValid(in_valid), .inAcc(in_acc), .inIsInf(in_inf),
    .adjustExp(adj4), .outValid(ovf_valid), .outData(ovf_data), .outIsZero(ovf_zero),
    .outIsInf(ovf_inf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: real-valued log2, integer leading-one search; returns {data, zero, inf}.
  function automatic logic [9:0] model(input logic [15:0] acc, input bit inf, input int adj,
                                       input bit use_adj, input bit sat);
    int  s, a, p, fb, k, t, q, e, data;
    bit  rem, st, g, r;
    real v;
    s = acc[15] ? 1 : 0;
    a = s ? 65536 - int'(acc) : int'(acc);
    if (inf) return {8'((s << 7) | 64), 1'b0, 1'b1};
    if (a == 0) return {8'h00, 1'b1, 1'b0};
    p = 0;
    for (int i = 0; i < 17; i++) if (((a >> i) & 1) == 1) p = i;
    fb = a - (1 << p);
    if (p >= 8) begin
      k   = fb >> (p - 8);
      rem = (fb & ((1 << (p - 8)) - 1)) != 0;
    end else begin
      k   = fb << (8 - p);
      rem = 0;
    end
    v  = $ln(1.0 + real'(k) / 256.0) / $ln(2.0) * 32.0;
    t  = $rtoi($floor(v));
    st = rem || (v > real'(t));
    q  = t >> 2;
    g  = ((t >> 1) & 1) == 1;
    r  = (t & 1) == 1;
    if (g && (r || st || ((q & 1) == 1))) q++;
    e = p - 8;
    if (q == 8) begin q = 0; e++; end
    if (use_adj) e += adj;
    if (e > 7) begin
      if (sat) return {8'((s << 7) | (7 << 3) | 7), 1'b0, 1'b0};
      return {8'((s << 7) | 64), 1'b0, 1'b1};
    end
    if (e < -8 || (e == -8 && q == 0)) return {8'h00, 1'b1, 1'b0};
    data = (s << 7) | ((e & 15) << 3) | q;
    return {8'(data), 1'b0, 1'b0};
  endfunction

  task automatic send(input logic [15:0] acc, input logic inf, input logic [3:0] a4,
                      input logic [9:0] exp_res);
    in_valid = 1'b1;
    in_acc   = acc;
    in_inf   = inf;
    adj4     = a4;
    adj1     = 1'($urandom_range(0, 1));
    sb.push_back('{res: exp_res, cyc: cyc});
    @(posedge clock); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_acc   = 16'($urandom);
    in_inf   = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
  endtask

  // Scoreboard: every valid output pops one expectation and must be exactly 2 cycles old.
  always @(negedge clock) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_outValid got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t ex;
        ex = sb.pop_front();
        chk("latency", 32'(cyc - ex.cyc), 32'd2);
        chk("result", {22'd0, out_data, out_zero, out_inf}, {22'd0, ex.res});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] acc;
    logic        inf;
    tab[0]  = '{16'h0100, 1'b0, 8'h00, 1'b0, 1'b0};  // 1.0
    tab[1]  = '{16'h0200, 1'b0, 8'h08, 1'b0, 1'b0};  // 2.0
    tab[2]  = '{16'hFF80, 1'b0, 8'hF8, 1'b0, 1'b0};  // -0.5
    tab[3]  = '{16'h0300, 1'b0, 8'h0D, 1'b0, 1'b0};  // 3.0 -> frac 101
    tab[4]  = '{16'h0001, 1'b0, 8'h00, 1'b1, 1'b0};  // 2^-8 flushes
    tab[5]  = '{16'h0000, 1'b0, 8'h00, 1'b1, 1'b0};  // zero
    tab[6]  = '{16'h8000, 1'b1, 8'hC0, 1'b0, 1'b1};  // Inf, negative
    tab[7]  = '{16'h7FFF, 1'b0, 8'h38, 1'b0, 1'b0};  // rounding carry -> exp 7
    tab[8]  = '{16'h8000, 1'b0, 8'hB8, 1'b0, 1'b0};  // -128, no wrap
    tab[9]  = '{16'h0000, 1'b1, 8'h40, 1'b0, 1'b1};  // Inf overrides zero
    tab[10] = '{16'hFFFF, 1'b0, 8'h00, 1'b1, 1'b0};  // -2^-8 flushes, sign dropped
    tab[11] = '{16'h0002, 1'b0, 8'h48, 1'b0, 1'b0};  // 2^-7 -> exp -7
    tab[12] = '{16'h4000, 1'b0, 8'h30, 1'b0, 1'b0};  // 64.0

    reset = 1'b1; in_valid = 1'b0; in_acc = '0; in_inf = 1'b0; adj1 = '0; adj4 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_outValid", 32'(out_valid), 32'd0);
    chk("rst_outData", 32'(out_data), 32'd0);
    chk("rst_outIsZero", 32'(out_zero), 32'd0);
    chk("rst_outIsInf", 32'(out_inf), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed vectors back-to-back
    for (int i = 0; i < 13; i++)
      send(tab[i].acc, tab[i].inf, 4'h0, {tab[i].data, tab[i].zero, tab[i].is_inf});
    idle();

    // 64.0 with +4 overflows, with -8 lands at exponent -2
    send(16'h4000, 1'b0, 4'h4, model(16'h4000, 1'b0, 0, 1'b0, 1'b1));
    send(16'h4000, 1'b0, 4'h8, model(16'h4000, 1'b0, 0, 1'b0, 1'b1));
    in_valid = 1'b0;
    @(negedge clock);
    chk("sat_valid", 32'(sat_valid), 32'd1);
    chk("sat_overflow", {22'd0, sat_data, sat_zero, sat_inf}, {22'd0, 8'h3F, 1'b0, 1'b0});
    chk("inf_overflow", {22'd0, ovf_data, ovf_zero, ovf_inf}, {22'd0, 8'h40, 1'b0, 1'b1});
    @(negedge clock);
    chk("sat_adjust_neg", {22'd0, sat_data, sat_zero, sat_inf}, {22'd0, 8'h70, 1'b0, 1'b0});
    chk("inf_adjust_neg", {22'd0, ovf_data, ovf_zero, ovf_inf}, {22'd0, 8'h70, 1'b0, 1'b0});
    @(posedge clock); #1;

    // Random stream with a reset pulse in the middle
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        reset    = 1'b1;
        in_valid = 1'b1;
        in_acc   = 16'($urandom);
        @(posedge clock); #1;
        sb.delete();
        @(negedge clock);
        chk("midrst_outValid", 32'(out_valid), 32'd0);
        chk("midrst_outData", 32'(out_data), 32'd0);
        chk("midrst_outIsZero", 32'(out_zero), 32'd0);
        chk("midrst_outIsInf", 32'(out_inf), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
      end
      case ($urandom_range(0, 7))
        0:       acc = 16'($urandom_range(0, 3));
        1:       acc = 16'h8000 | 16'($urandom_range(0, 2));
        default: acc = 16'($urandom);
      endcase
      inf = ($urandom_range(0, 15) == 0);
      if (i != 50 && $urandom_range(0, 9) == 0) idle();
      else send(acc, inf, 4'h0, model(acc, inf, 0, 1'b0, 1'b1));
    end
    repeat (4) idle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
